// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit for the EX stage; results land in HI/LO.
// Latency: WIDTH+2 cycles from start to done (divide-by-zero: 1 cycle).
// Backpressure: stall holds ID/EX and earlier stages; start is ignored while busy.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    // multiplicand for multiply, divisor for divide
    logic [WIDTH-1:0]   r_opnd;
    // multiply: {partial product, remaining multiplier}; divide: low half is dividend/quotient
    logic [2*WIDTH-1:0] r_acc;
    // partial remainder; one bit wider than the operands so the shift never overflows
    logic [WIDTH:0]     r_rem;

    logic               w_is_div;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_start_ok;
    logic               w_div0;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH+1:0]   w_div_shift;
    logic [WIDTH+1:0]   w_div_diff;
    logic               w_div_borrow;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand decode: signed ops work on magnitudes and remember the signs.
    assign w_is_div   = op[1];
    assign w_signed   = op[0];
    assign w_sign_a   = w_signed & srcA[WIDTH-1];
    assign w_sign_b   = w_signed & srcB[WIDTH-1];
    assign w_mag_a    = w_sign_a ? (WIDTH'(0) - srcA) : srcA;
    assign w_mag_b    = w_sign_b ? (WIDTH'(0) - srcB) : srcB;
    assign w_start_ok = start & (r_state == S_IDLE);
    assign w_div0     = w_start_ok & w_is_div & (srcB == '0);

    // One shift-add step: add multiplicand when the current multiplier LSB is set.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // One restoring-divide step: the subtract borrow decides the quotient bit.
    assign w_div_shift  = {r_rem, r_acc[WIDTH-1]};
    assign w_div_diff   = w_div_shift - {2'b00, r_opnd};
    assign w_div_borrow = w_div_diff[WIDTH+1];

    // Sign correction; sign flags are zero for unsigned ops so no correction happens.
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? ((2*WIDTH)'(0) - r_acc) : r_acc;
    assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_sign_a ? (WIDTH'(0) - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = w_start_ok | r_busy;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: divide-by-zero completes from IDLE without running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok && !w_div0) w_state_nxt = S_RUN;
            S_RUN:   if (r_count == LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_div0) begin
                        r_hi   <= srcA;
                        r_lo   <= '1;
                        r_done <= 1'b1;
                    end else if (w_start_ok) begin
                        r_is_div <= w_is_div;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                        r_rem    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + CW'(1);
                    if (r_is_div) begin
                        r_rem <= w_div_borrow ? w_div_shift[WIDTH:0] : w_div_diff[WIDTH:0];
                        r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_div_borrow};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
